// File: rtl/gray_step_monitor.sv
// Gray-code step monitor: registers and converts each gray sample to binary, classifies the step,
// tracks acquire/lock status and counts illegal steps. Build macro: GRAY_STEP_MON_DIRCHK_EN.
module gray_step_monitor #(
  parameter int W        = 4,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             ret,
  input  logic [W-1:0]     gray_in,
  input  logic             gray_vld,
  output logic [W-1:0]     bin_out,
  output logic             bin_vld,
  output logic             dir,
  output logic             step_err,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       o_dbg_state   // 0 = ACQ, 1 = TRACK, 2 = LOCKED
);

  typedef enum logic [1:0] {
    ST_ACQ    = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LC = 4'(LOCK_CNT);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_good_cnt;
  logic [3:0]       w_good_nxt;
  logic [W-1:0]     r_prev_gray;
  logic [W-1:0]     w_prev_nxt;
  logic [W-1:0]     r_bin;
  logic [W-1:0]     w_bin_nxt;
  logic             r_bin_vld;
  logic             w_bin_vld_nxt;
  logic             r_dir;
  logic             w_dir_nxt;
  logic             r_step_err;
  logic             w_step_err_nxt;
  logic [ERR_W-1:0] r_err_cnt;
  logic             w_err_inc;

  logic [W-1:0]     w_new_bin;
  logic [W-1:0]     w_prev_bin;
  logic [W-1:0]     w_diff;
  logic             w_d_zero;
  logic             w_d_one;
  logic             w_up;
  logic             w_rev;
  logic             w_bad;

  // Each binary bit is the XOR of all gray bits at or above it.
  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = '0;
    for (int i = 0; i < W; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  always_comb begin
    w_new_bin  = gray2bin(gray_in);
    w_prev_bin = gray2bin(r_prev_gray);
    w_diff     = gray_in ^ r_prev_gray;
    w_d_zero   = (w_diff == '0);
    w_d_one    = $onehot(w_diff);
    w_up       = (w_new_bin == w_prev_bin + W'(1));
  end

`ifdef GRAY_STEP_MON_DIRCHK_EN
  // A single-bit step against the established direction while locked is treated as illegal.
  assign w_rev = (r_state == ST_LOCKED) && w_d_one && (w_up != r_dir);
`else
  assign w_rev = 1'b0;
`endif

  assign w_bad = !w_d_zero && (!w_d_one || w_rev);

  always_ff @(posedge clk) begin
    if (ret) begin
      r_state <= ST_ACQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_good_nxt     = r_good_cnt;
    w_prev_nxt     = r_prev_gray;
    w_bin_nxt      = r_bin;
    w_bin_vld_nxt  = 1'b0;
    w_dir_nxt      = r_dir;
    w_step_err_nxt = 1'b0;
    w_err_inc      = 1'b0;
    if (gray_vld) begin
      w_bin_vld_nxt = 1'b1;
      case (r_state)
        ST_ACQ: begin
          w_prev_nxt  = gray_in;
          w_bin_nxt   = w_new_bin;
          w_good_nxt  = 4'd0;
          w_state_nxt = ST_TRACK;
        end
        ST_TRACK, ST_LOCKED: begin
          if (!w_d_zero) begin
            w_prev_nxt = gray_in;
            w_bin_nxt  = w_new_bin;
            if (w_d_one) begin
              w_dir_nxt = w_up;
            end
            if (w_bad) begin
              w_step_err_nxt = 1'b1;
              w_err_inc      = 1'b1;
              w_good_nxt     = 4'd0;
              w_state_nxt    = ST_TRACK;
            end else if (r_state == ST_TRACK) begin
              w_good_nxt = r_good_cnt + 4'd1;
              if (r_good_cnt + 4'd1 >= LC) begin
                w_state_nxt = ST_LOCKED;
              end
            end
          end
        end
        default: begin
          w_state_nxt = ST_ACQ;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ret) begin
      r_good_cnt  <= 4'd0;
      r_prev_gray <= '0;
      r_bin       <= '0;
      r_bin_vld   <= 1'b0;
      r_dir       <= 1'b0;
      r_step_err  <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_good_cnt  <= w_good_nxt;
      r_prev_gray <= w_prev_nxt;
      r_bin       <= w_bin_nxt;
      r_bin_vld   <= w_bin_vld_nxt;
      r_dir       <= w_dir_nxt;
      r_step_err  <= w_step_err_nxt;
      if (w_err_inc && (r_err_cnt != {ERR_W{1'b1}})) begin
        r_err_cnt <= r_err_cnt + ERR_W'(1);
      end
    end
  end

  assign bin_out     = r_bin;
  assign bin_vld     = r_bin_vld;
  assign dir         = r_dir;
  assign step_err    = r_step_err;
  assign locked      = (r_state == ST_LOCKED);
  assign err_cnt     = r_err_cnt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_gray_step_monitor.sv
// Bench for gray_step_monitor: directed scenarios then random traffic against a behavioural model;
// a second instance with a 2-bit error counter exercises saturation.
module tb_gray_step_monitor;

  localparam int LOCK_CNT = 2;

  logic       clk = 1'b0;
  logic       ret = 1'b1;
  logic [3:0] gray_in = '0;
  logic       gray_vld = 1'b0;

  logic [3:0] bin_out, bin_out_s;
  logic       bin_vld, bin_vld_s;
  logic       dir, dir_s;
  logic       step_err, step_err_s;
  logic       locked, locked_s;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt_s;
  logic [1:0] dbg_state, dbg_state_s;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  bit         m_ref;
  logic [3:0] m_prev;
  logic [3:0] m_bin;
  bit         m_bin_vld, m_dir, m_step_err;
  int         m_good, m_st, m_errs;
  logic [3:0] exp_q[$];
  logic [3:0] last_g;
  bit         rnd_up;

  gray_step_monitor #(.W(4), .LOCK_CNT(LOCK_CNT), .ERR_W(8)) dut (
    .clk(clk), .ret(ret), .gray_in(gray_in), .gray_vld(gray_vld),
    .bin_out(bin_out), .bin_vld(bin_vld), .dir(dir), .step_err(step_err),
    .locked(locked), .err_cnt(err_cnt), .o_dbg_state(dbg_state)
  );

  gray_step_monitor #(.W(4), .LOCK_CNT(LOCK_CNT), .ERR_W(2)) dut_s (
    .clk(clk), .ret(ret), .gray_in(gray_in), .gray_vld(gray_vld),
    .bin_out(bin_out_s), .bin_vld(bin_vld_s), .dir(dir_s), .step_err(step_err_s),
    .locked(locked_s), .err_cnt(err_cnt_s), .o_dbg_state(dbg_state_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int g2b(input int g);
    return (g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3)) & 15;
  endfunction

  function automatic logic [3:0] b2g(input int b);
    return 4'((b ^ (b >> 1)) & 15);
  endfunction

  // Behavioural model of one clock edge.
  task automatic model(input bit rst, input bit vld, input logic [3:0] g);
    int  d, nb, pb;
    bit  up, bad;
    if (rst) begin
      m_ref = 0; m_prev = 0; m_bin = 0; m_bin_vld = 0; m_dir = 0;
      m_step_err = 0; m_good = 0; m_st = 0; m_errs = 0;
      return;
    end
    m_bin_vld = vld;
    m_step_err = 0;
    if (!vld) return;
    if (m_st == 0) begin
      m_prev = g; m_bin = 4'(g2b(int'(g))); m_st = 1; m_good = 0;
    end else begin
      d = $countones(g ^ m_prev);
      if (d != 0) begin
        nb  = g2b(int'(g));
        pb  = g2b(int'(m_prev));
        up  = (nb == ((pb + 1) % 16));
        bad = (d > 1);
        if (d == 1) begin
`ifdef GRAY_STEP_MON_DIRCHK_EN
          if (m_st == 2 && up != m_dir) bad = 1;
`endif
          m_dir = up;
        end
        m_prev = g;
        m_bin  = 4'(nb);
        if (bad) begin
          m_step_err = 1; m_errs++; m_st = 1; m_good = 0;
        end else if (m_st == 1) begin
          m_good++;
          if (m_good >= LOCK_CNT) m_st = 2;
        end
      end
    end
    exp_q.push_back(m_bin);
  endtask

  task automatic compare_all();
    check("bin_vld", bin_vld, m_bin_vld);
    if (bin_vld) begin
      if (exp_q.size() == 0) check("bin_extra", exp_q.size(), 1);
      else check("bin_out_q", bin_out, exp_q.pop_front());
    end
    if (exp_q.size() != 0) begin
      check("bin_missing", exp_q.size(), 0);
      exp_q.delete();
    end
    check("bin_out", bin_out, m_bin);
    check("dir", dir, m_dir);
    check("step_err", step_err, m_step_err);
    check("locked", locked, m_st == 2);
    check("state", dbg_state, m_st);
    check("err_cnt", err_cnt, (m_errs > 255) ? 255 : m_errs);
    check("err_cnt_sat", err_cnt_s, (m_errs > 3) ? 3 : m_errs);
    check("step_err_s", step_err_s, m_step_err);
    check("bin_out_s", bin_out_s, m_bin);
  endtask

  task automatic cyc(input bit rst, input bit vld, input logic [3:0] g);
    @(negedge clk);
    ret = rst; gray_vld = vld; gray_in = g;
    if (vld && !rst) last_g = g;
    @(posedge clk);
    model(rst, vld, g);
    #1 compare_all();
  endtask

  initial begin
    int r;
    logic [3:0] g, m;
    last_g = '0;
    rnd_up = 1;

    // Reset with valid traffic present must be ignored.
    cyc(1, 1, 4'b0110);
    cyc(1, 1, 4'b0110);
    check("rst_bin_vld", bin_vld, 0);
    check("rst_state", dbg_state, 0);

    // Up count 0..4, then on to 15, hold, wrap.
    for (int b = 0; b <= 4; b++) cyc(0, 1, b2g(b));
    check("up_bin4", bin_out, 4);
    check("up_locked", locked, 1);
    check("up_dir", dir, 1);
    for (int b = 5; b <= 15; b++) cyc(0, 1, b2g(b));
    cyc(0, 1, 4'b1000);
    check("hold_bin15", bin_out, 15);
    check("hold_vld", bin_vld, 1);
    cyc(0, 0, 4'b1111);
    check("idle_vld", bin_vld, 0);
    cyc(0, 1, 4'b0000);
    check("wrap_bin0", bin_out, 0);
    check("wrap_locked", locked, 1);

    // Illegal jump from locked at gray 0001, then relock.
    cyc(0, 1, 4'b0001);
    cyc(0, 1, 4'b0110);
    check("jump_err", step_err, 1);
    check("jump_bin4", bin_out, 4);
    check("jump_unlocked", locked, 0);
    cyc(0, 1, b2g(5));
    cyc(0, 1, b2g(6));
    check("relock", locked, 1);

    // Saturation with five illegal jumps.
    cyc(1, 0, 4'b0000);
    cyc(0, 1, 4'b0101);
    for (int k = 0; k < 5; k++) cyc(0, 1, (k % 2 == 0) ? 4'b1010 : 4'b0101);
    check("sat_cnt2", err_cnt_s, 3);
    check("sat_cnt8", err_cnt, 5);

    // Reversal while locked going up.
    cyc(1, 0, 4'b0000);
    for (int b = 2; b <= 5; b++) cyc(0, 1, b2g(b));
    cyc(0, 1, b2g(4));
    check("rev_dir", dir, 0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        cyc(1, $urandom_range(0, 1), 4'($urandom_range(0, 15)));
      end else if (r < 15) begin
        cyc(0, 0, 4'($urandom_range(0, 15)));
      end else if (r < 25) begin
        cyc(0, 1, last_g);
      end else if (r < 37) begin
        m = 4'($urandom_range(1, 15));
        while ($countones(m) < 2) m = 4'($urandom_range(1, 15));
        cyc(0, 1, last_g ^ m);
      end else begin
        if (r < 43) rnd_up = !rnd_up;
        g = b2g((g2b(int'(last_g)) + (rnd_up ? 1 : 15)) % 16);
        cyc(0, 1, g);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gray_step_monitor.md
Name: gray_step_monitor

Overview:
- Downstream consumer of the 4-bit gray counter output.
- Registers each sampled gray code and converts it to binary with one cycle of latency.
- Checks that consecutive codes differ by exactly one bit and reports count direction.
- Tracks lock/acquire status and keeps a saturating error count for bench and system monitoring.

Parameters:
W, 4, gray/binary code width
LOCK_CNT, 2, consecutive good steps needed to assert locked (range 1..15)
ERR_W, 8, width of the saturating error counter

Ports:
clk  input  1  clock, all logic on rising edge
ret  input  1  synchronous active-high reset
gray_in  input  W  gray code sample
gray_vld  input  1  gray_in is valid this cycle
bin_out  output  W  registered binary equivalent of the last accepted gray_in
bin_vld  output  1  1-cycle pulse: bin_out updated
dir  output  1  direction of last good step: 1 = up, 0 = down
step_err  output  1  1-cycle pulse: illegal transition detected
locked  output  1  tracking is stable
err_cnt  output  ERR_W  saturating count of illegal transitions

Behaviour:
- Interface: one clock, clk. Reset ret is synchronous and active-high, and is sampled on the clk rising edge.
- Reset, or any cycle with ret=1:
  - bin_out=0, bin_vld=0, dir=0, step_err=0, locked=0, err_cnt=0.
  - State=ACQ, good_cnt=0, stored previous gray=0.
- ret has priority over gray_vld.
- Conversion: bin[W-1]=g[W-1]; bin[i]=bin[i+1]^g[i].
  - Registered, so latency is 1 cycle: a sample at edge N appears on bin_out/bin_vld after edge N.
- gray_vld=0: all outputs hold, except bin_vld and step_err, which drop to 0. No state change.
- Step classification on gray_vld=1, using Hamming distance d between gray_in and the stored previous gray:
  - d=0: hold. bin_vld=1, bin_out unchanged, dir unchanged, good_cnt unchanged, no error.
  - d=1: good step. dir=1 if new_bin == (prev_bin+1) mod 2^W, otherwise dir=0.
  - d>1: illegal. step_err=1 for one cycle; err_cnt increments and saturates at 2^ERR_W-1. bin_out still updates and the new gray becomes the reference.
- Wrap-around: gray 1000 (bin 15) to 0000 (bin 0) is a legal up step. 0000 to 1000 is a legal down step.
- FSM:
  - ACQ: no reference yet. The first valid sample is stored, bin_out/bin_vld update, no error or direction evaluation, then go to TRACK with good_cnt=0.
  - TRACK:
    - Good step: good_cnt++; when good_cnt reaches LOCK_CNT, go to LOCKED and set locked=1 on the same edge.
    - Illegal step: good_cnt=0, stay in TRACK.
  - LOCKED:
    - Good step: stay.
    - Illegal step: go to TRACK, locked=0, good_cnt=0.
- Errors are counted only in TRACK and LOCKED, never in ACQ.
- Reset mid-operation returns to ACQ on the next edge. The next sample is treated as the first sample, with no error.

Optional Feature:
- Macro: GRAY_STEP_MON_DIRCHK_EN.
- Defined: in LOCKED, a d=1 step whose direction differs from the current dir counts as illegal:
  - step_err pulses and err_cnt increments;
  - the FSM goes to TRACK;
  - dir updates to the new direction.
- Not defined: direction reversals are legal good steps that only update dir. No direction-reversal logic is synthesised.

Test Plan:
- Reset: ret=1 for 2 cycles with gray_vld=1 and gray_in=0110 -> all outputs 0, state ACQ, no bin_vld pulse.
- Up count: feed gray 0000, 0001, 0011, 0010, 0110 on consecutive cycles -> bin_out 0, 1, 2, 3, 4, each one cycle late; dir=1; locked=1 after the third sample edge; step_err never set.
- Wrap and hold: from locked at gray 1000 (bin 15), feed 1000 again, then 0000 -> hold keeps bin_out=15 with bin_vld=1; then bin_out=0, dir=1, no error, locked stays 1.
- Illegal jump: locked at gray 0001, feed 0110 -> step_err pulses once, err_cnt=1, locked=0 on the same edge, bin_out=4. Two further good steps re-assert locked.
- Saturation: ERR_W=2, apply 5 illegal jumps -> err_cnt goes 1, 2, 3, 3, 3; step_err pulses 5 times.
- Reversal: locked going up at bin 5, feed gray for bin 4 -> without the macro, dir=0 and no error. With GRAY_STEP_MON_DIRCHK_EN defined, step_err=1, err_cnt+1, locked=0, dir=0.
